// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO pointer/flag controller.
// Imported by the interface, the pointer sub-module and the top.
package fifo_pkg;

    localparam int FIFO_ADDR_SIZE = 4;
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_AFULL     = 14;
    localparam int FIFO_AEMPTY    = 2;
    localparam int FIFO_CNT_W     = FIFO_ADDR_SIZE + 1;

    // {write, read} strobe pair, used to steer the occupancy update
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Request/strobe/status bundle between a FIFO user and fifo_ctrl.
// master = producer/consumer side, slave = the controller.
interface fifo_ctrl_if #(
    parameter int ADDR_SIZE = fifo_pkg::FIFO_ADDR_SIZE
);

    localparam int CNT_W = ADDR_SIZE + 1;

    logic                 clear;
    logic                 push;
    logic                 pop;
    logic                 write_en;
    logic                 read_en;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rd_valid;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output clear, push, pop,
        input  write_en, read_en, wr_addr, rd_addr,
        input  rd_valid, count, full, empty,
        input  almost_full, almost_empty,
        input  overflow, underflow
    );

    modport slave (
        input  clear, push, pop,
        output write_en, read_en, wr_addr, rd_addr,
        output rd_valid, count, full, empty,
        output almost_full, almost_empty,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer with increment enable and sync clear.
// Wraps through the natural overflow of the W-bit register.
module fifo_ptr #(
    parameter int W = fifo_pkg::FIFO_ADDR_SIZE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    logic [W-1:0] r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving a dual-port RAM with a
// one-cycle registered read; flags decode from the registered count.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE     = FIFO_ADDR_SIZE,
    parameter int RAM_DEPTH     = FIFO_DEPTH,
    parameter int AFULL_THRESH  = FIFO_AFULL,
    parameter int AEMPTY_THRESH = FIFO_AEMPTY
) (
    input  logic       clk,
    input  logic       reset,
    fifo_ctrl_if.slave bus
);

    localparam int CNT_W = ADDR_SIZE + 1;
    localparam logic [CNT_W-1:0] L_DEPTH  = CNT_W'(RAM_DEPTH);
    localparam logic [CNT_W-1:0] L_AFULL  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] L_AEMPTY = CNT_W'(AEMPTY_THRESH);

    logic [CNT_W-1:0]     r_count;
    logic                 r_rd_valid;
    logic                 r_overflow;
    logic                 r_underflow;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_read_en;
    logic                 w_write_en;
    logic [ADDR_SIZE-1:0] w_wr_ptr;
    logic [ADDR_SIZE-1:0] w_rd_ptr;
    fifo_op_e             w_op;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == L_DEPTH);

    // Reset gates the strobes so the RAM sees no access while held
    assign w_read_en  = reset & ~bus.clear & bus.pop & ~w_empty;
    assign w_write_en = reset & ~bus.clear & bus.push
                      & (~w_full | w_read_en);
    assign w_op       = fifo_op_e'({w_write_en, w_read_en});

    fifo_ptr #(.W(ADDR_SIZE)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .i_clr (bus.clear),
        .i_inc (w_write_en),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.W(ADDR_SIZE)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .i_clr (bus.clear),
        .i_inc (w_read_en),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (bus.clear) begin
            r_count <= '0;
        end else begin
            unique case (w_op)
                OP_WR:   r_count <= r_count + 1'b1;
                OP_RD:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clear) begin
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid  <= w_read_en;
            r_overflow  <= r_overflow | (bus.push & ~w_write_en);
            r_underflow <= r_underflow | (bus.pop & ~w_read_en);
        end
    end

    always_ff @(posedge clk) begin
        a_params: assert (RAM_DEPTH == 2**ADDR_SIZE &&
                          AFULL_THRESH <= RAM_DEPTH);
    end

    assign bus.write_en     = w_write_en;
    assign bus.read_en      = w_read_en;
    assign bus.wr_addr      = w_wr_ptr;
    assign bus.rd_addr      = w_rd_ptr;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= L_AFULL);
    assign bus.almost_empty = (r_count <= L_AEMPTY);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: vector table, corner sequences and random
// traffic against a queue-based model with a behavioural RAM.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    logic clk;
    logic reset;
    logic [7:0] wdata;
    logic [7:0] mem [FIFO_DEPTH];
    logic [7:0] ram_q;

    fifo_ctrl_if bus ();

    fifo_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: read-first, one-cycle registered read
    always @(posedge clk) begin
        if (bus.write_en) mem[bus.wr_addr] <= wdata;
        if (bus.read_en)  ram_q <= mem[bus.rd_addr];
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] q [$];
    int  m_wp, m_rp;
    bit  m_ov, m_un, m_rv, m_we, m_re;
    logic [7:0] m_rdata;
    bit  s_we, s_re;

    typedef struct {
        bit push; bit pop; bit clr;
        bit we;   bit re;
        int cnt;  bit un;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_wp = 0; m_rp = 0;
        m_ov = 0; m_un = 0; m_rv = 0;
    endtask

    task automatic check_all();
        int c;
        c = q.size();
        m_re = !bus.clear && bus.pop && c != 0;
        m_we = !bus.clear && bus.push &&
               (c != FIFO_DEPTH || m_re);
        chk("count", 32'(bus.count), c);
        chk("empty", 32'(bus.empty), c == 0);
        chk("full", 32'(bus.full), c == FIFO_DEPTH);
        chk("afull", 32'(bus.almost_full), c >= FIFO_AFULL);
        chk("aempty", 32'(bus.almost_empty), c <= FIFO_AEMPTY);
        chk("wr_addr", 32'(bus.wr_addr), m_wp);
        chk("rd_addr", 32'(bus.rd_addr), m_rp);
        chk("overflow", 32'(bus.overflow), m_ov);
        chk("underflow", 32'(bus.underflow), m_un);
        chk("rd_valid", 32'(bus.rd_valid), m_rv);
        chk("write_en", 32'(bus.write_en), m_we);
        chk("read_en", 32'(bus.read_en), m_re);
        if (m_rv) chk("rdata", 32'(ram_q), 32'(m_rdata));
    endtask

    task automatic model_step();
        if (bus.clear) begin
            model_reset();
        end else begin
            if (m_re) begin
                m_rdata = q.pop_front();
                m_rp = (m_rp + 1) % FIFO_DEPTH;
            end
            if (m_we) begin
                q.push_back(wdata);
                m_wp = (m_wp + 1) % FIFO_DEPTH;
            end
            m_ov = m_ov | (bus.push && !m_we);
            m_un = m_un | (bus.pop && !m_re);
            m_rv = m_re;
        end
    endtask

    // Called at a negedge; returns at the following negedge
    task automatic cycle(bit p, bit o, bit c, logic [7:0] d);
        bus.push = p; bus.pop = o; bus.clear = c; wdata = d;
        #1;
        check_all();
        s_we = bus.write_en;
        s_re = bus.read_en;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 1, 0, 1, 1};
        tbl[1] = '{0, 1, 0, 0, 1, 0, 1};
        tbl[2] = '{0, 0, 0, 0, 0, 0, 1};
        tbl[3] = '{1, 0, 0, 1, 0, 1, 1};
        tbl[4] = '{1, 0, 0, 1, 0, 2, 1};
        tbl[5] = '{1, 1, 0, 1, 1, 2, 1};
        tbl[6] = '{1, 1, 1, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 0, 0, 0, 0, 1};
        tbl[8] = '{1, 0, 0, 1, 0, 1, 1};
        tbl[9] = '{0, 1, 0, 0, 1, 0, 1};

        reset = 1'b0;
        bus.push = 0; bus.pop = 0; bus.clear = 0; wdata = '0;
        model_reset();
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_aempty", 32'(bus.almost_empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_afull", 32'(bus.almost_full), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].push, tbl[i].pop, tbl[i].clr, 8'(i));
            chk($sformatf("tbl%0d_we", i), 32'(s_we), tbl[i].we);
            chk($sformatf("tbl%0d_re", i), 32'(s_re), tbl[i].re);
            chk($sformatf("tbl%0d_cnt", i), 32'(bus.count),
                tbl[i].cnt);
            chk($sformatf("tbl%0d_un", i), 32'(bus.underflow),
                tbl[i].un);
        end

        // Fill from empty, then overflow
        cycle(0, 0, 1, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0, 8'(i));
            chk("fill_wr_addr", 32'(bus.wr_addr), (i + 1) % 16);
        end
        chk("fill_full", 32'(bus.full), 1);
        cycle(1, 0, 0, 8'hEE);
        chk("ovf_we", 32'(s_we), 0);
        chk("ovf_flag", 32'(bus.overflow), 1);
        cycle(0, 0, 0, 8'h00);
        chk("ovf_sticky", 32'(bus.overflow), 1);

        // Drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 8'h00);
            chk("drain_rdata", 32'(ram_q), i);
        end
        cycle(0, 1, 0, 8'h00);
        chk("unf_re", 32'(s_re), 0);
        chk("unf_flag", 32'(bus.underflow), 1);
        chk("drain_empty", 32'(bus.empty), 1);

        // Full with simultaneous push and pop; wr_ptr wraps
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'(8'h20 + i));
        cycle(1, 1, 0, 8'h99);
        chk("fullrw_we", 32'(s_we), 1);
        chk("fullrw_re", 32'(s_re), 1);
        chk("fullrw_cnt", 32'(bus.count), 16);
        chk("fullrw_old", 32'(ram_q), 32'h20);
        for (int i = 0; i < 16; i++) cycle(0, 1, 0, 8'h00);
        cycle(0, 0, 0, 8'h00);
        chk("wrap_last", 32'(ram_q), 32'h99);

        // Empty with simultaneous push and pop
        cycle(0, 0, 1, 8'h00);
        cycle(1, 1, 0, 8'h5A);
        chk("erw_we", 32'(s_we), 1);
        chk("erw_re", 32'(s_re), 0);
        chk("erw_un", 32'(bus.underflow), 1);
        chk("erw_cnt", 32'(bus.count), 1);
        cycle(0, 0, 0, 8'h00);
        chk("erw_rv", 32'(bus.rd_valid), 0);

        // Clear at count 9 with overflow set
        cycle(0, 0, 1, 8'h00);
        for (int i = 0; i < 17; i++) cycle(1, 0, 0, 8'(i));
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'h00);
        chk("pre_clr_cnt", 32'(bus.count), 9);
        chk("pre_clr_ov", 32'(bus.overflow), 1);
        cycle(1, 1, 1, 8'h77);
        chk("clr_we", 32'(s_we), 0);
        chk("clr_re", 32'(s_re), 0);
        chk("clr_cnt", 32'(bus.count), 0);
        chk("clr_wp", 32'(bus.wr_addr), 0);
        chk("clr_rp", 32'(bus.rd_addr), 0);
        chk("clr_ov", 32'(bus.overflow), 0);
        chk("clr_un", 32'(bus.underflow), 0);

        // Asynchronous reset mid-stream at count 5
        cycle(0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'(i));
        cycle(0, 1, 0, 8'h00);
        cycle(1, 0, 0, 8'h05);
        bus.push = 1; bus.pop = 1;
        #3;
        reset = 1'b0;
        #1;
        chk("arst_we", 32'(bus.write_en), 0);
        chk("arst_re", 32'(bus.read_en), 0);
        chk("arst_cnt", 32'(bus.count), 0);
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_rv", 32'(bus.rd_valid), 0);
        chk("arst_un", 32'(bus.underflow), 0);
        @(posedge clk);
        #1;
        chk("arst_we2", 32'(bus.write_en), 0);
        chk("arst_cnt2", 32'(bus.count), 0);
        @(negedge clk);
        bus.push = 0; bus.pop = 0;
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 49) == 0,
                  8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
